// File: rtl/tcm_dual_port_mem.sv
// Tightly-coupled 128 KiB memory for a RISC-V core: 64-bit fetch port plus 32-bit data port.
// Both ports have a one-cycle registered response. Requests are always accepted, so there is no backpressure.
// Storage is one 16384 x 64-bit array. Simulation preloads it through the write() backdoor task.

module tcm_ram (
  input  logic        clk,
  input  logic        rst,
  // fetch side: read only
  input  logic        rd_a,
  input  logic [13:0] addr_a,
  output logic [63:0] rdata_a,
  // data side: read plus byte-enabled write
  input  logic        rd_b,
  input  logic [13:0] addr_b,
  input  logic [7:0]  be_b,
  input  logic [63:0] wdata_b,
  output logic [63:0] rdata_b
);

  // Contents survive reset; only the read registers are cleared.
  logic [63:0] ram [0:16383];

  // Byte-lane writes from the data port land at the request edge.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (be_b[i]) begin
        ram[addr_b][i*8 +: 8] <= wdata_b[i*8 +: 8];
      end
    end
  end

  // Fetch read register. A same-edge store is not yet visible, so the fetch sees the old word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_a <= 64'd0;
    end else if (rd_a) begin
      rdata_a <= ram[addr_a];
    end
  end

  // Data read register. It only loads on a read, so stores and maintenance leave the last value in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_b <= 64'd0;
    end else if (rd_b) begin
      rdata_b <= ram[addr_b];
    end
  end

  // Simulation backdoor: drop one byte into lane 'lane' of word 'idx'.
  task automatic write_byte(input logic [13:0] idx, input logic [2:0] lane, input logic [7:0] data);
    ram[idx][{lane, 3'b000} +: 8] <= data;
  endtask

endmodule

module tcm_dual_port_mem (
  input  logic        clk_i,
  input  logic        rst_i,
  // instruction port
  input  logic        mem_i_rd_i,
  input  logic        mem_i_flush_i,
  input  logic        mem_i_invalidate_i,
  input  logic [31:0] mem_i_pc_i,
  output logic        mem_i_accept_o,
  output logic        mem_i_valid_o,
  output logic        mem_i_error_o,
  output logic [63:0] mem_i_inst_o,
  // data port
  input  logic [31:0] mem_d_addr_i,
  input  logic [31:0] mem_d_data_wr_i,
  input  logic        mem_d_rd_i,
  input  logic [3:0]  mem_d_wr_i,
  input  logic        mem_d_cacheable_i,
  input  logic [10:0] mem_d_req_tag_i,
  input  logic        mem_d_invalidate_i,
  input  logic        mem_d_writeback_i,
  input  logic        mem_d_flush_i,
  output logic [31:0] mem_d_data_rd_o,
  output logic        mem_d_accept_o,
  output logic        mem_d_ack_o,
  output logic        mem_d_error_o,
  output logic [10:0] mem_d_resp_tag_o
);

  logic [13:0] i_word;
  logic [13:0] d_word;
  logic [7:0]  d_be;
  logic [63:0] d_wdata;
  logic        d_req;
  logic        d_hi_q;
  logic [63:0] d_rdata;

  // Bits above 16 are dropped, so the memory aliases every 128 KiB.
  assign i_word  = mem_i_pc_i[16:3];
  assign d_word  = mem_d_addr_i[16:3];
  assign d_req   = mem_d_rd_i | (|mem_d_wr_i) | mem_d_flush_i |
                   mem_d_invalidate_i | mem_d_writeback_i;

  // addr[2] steers the four byte enables to the low or high half of the 64-bit word.
  assign d_be    = mem_d_addr_i[2] ? {mem_d_wr_i, 4'b0000} : {4'b0000, mem_d_wr_i};
  assign d_wdata = {mem_d_data_wr_i, mem_d_data_wr_i};

  // Neither port can stall or fault.
  assign mem_i_accept_o = 1'b1;
  assign mem_i_error_o  = 1'b0;
  assign mem_d_accept_o = 1'b1;
  assign mem_d_error_o  = 1'b0;

  // Hints, cacheability, cache maintenance and sub-word address bits have no data effect.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, mem_i_flush_i, mem_i_invalidate_i, mem_d_cacheable_i,
                           mem_i_pc_i[31:17], mem_i_pc_i[2:0],
                           mem_d_addr_i[31:17], mem_d_addr_i[1:0]};

  tcm_ram u_ram (
    .clk     (clk_i),
    .rst     (rst_i),
    .rd_a    (mem_i_rd_i),
    .addr_a  (i_word),
    .rdata_a (mem_i_inst_o),
    .rd_b    (mem_d_rd_i),
    .addr_b  (d_word),
    .be_b    (d_be),
    .wdata_b (d_wdata),
    .rdata_b (d_rdata)
  );

  // Fetch valid follows the request by one cycle, one fetch per cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_i_valid_o <= 1'b0;
    end else begin
      mem_i_valid_o <= mem_i_rd_i;
    end
  end

  // Ack one cycle after any data request. The tag is captured with it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_d_ack_o      <= 1'b0;
      mem_d_resp_tag_o <= 11'd0;
    end else begin
      mem_d_ack_o <= d_req;
      if (d_req) begin
        mem_d_resp_tag_o <= mem_d_req_tag_i;
      end
    end
  end

  // Half-select for load data. It updates only on loads, so it stays aligned with the held read word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      d_hi_q <= 1'b0;
    end else if (mem_d_rd_i) begin
      d_hi_q <= mem_d_addr_i[2];
    end
  end

  assign mem_d_data_rd_o = d_hi_q ? d_rdata[63:32] : d_rdata[31:0];

  // Simulation backdoor: store one byte at a byte address, little-endian within the 64-bit word.
  task automatic write(input logic [31:0] addr, input logic [7:0] data);
    u_ram.write_byte(addr[16:3], addr[2:0], data);
  endtask

endmodule

// File: tb/tb_tcm_dual_port_mem.sv
// Directed bench for tcm_dual_port_mem: table of per-cycle stimulus with expected outputs,
// plus hand sequences for reset, aliasing and backdoor/RAM contents.
// Inputs change 1 ns after the rising edge; outputs are sampled at the same point.

module tb_tcm_dual_port_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_rd = 1'b0, i_flush = 1'b0, i_inv = 1'b0;
  logic [31:0] i_pc = 32'd0;
  logic        i_accept, i_valid, i_error;
  logic [63:0] i_inst;
  logic [31:0] d_addr = 32'd0, d_wdata = 32'd0;
  logic        d_rd = 1'b0, d_cache = 1'b0, d_inv = 1'b0, d_wb = 1'b0, d_flush = 1'b0;
  logic [3:0]  d_wr = 4'd0;
  logic [10:0] d_tag = 11'd0;
  logic [31:0] d_rdata;
  logic        d_accept, d_ack, d_error;
  logic [10:0] d_rtag;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tcm_dual_port_mem dut (
    .clk_i(clk), .rst_i(rst),
    .mem_i_rd_i(i_rd), .mem_i_flush_i(i_flush), .mem_i_invalidate_i(i_inv), .mem_i_pc_i(i_pc),
    .mem_i_accept_o(i_accept), .mem_i_valid_o(i_valid), .mem_i_error_o(i_error), .mem_i_inst_o(i_inst),
    .mem_d_addr_i(d_addr), .mem_d_data_wr_i(d_wdata), .mem_d_rd_i(d_rd), .mem_d_wr_i(d_wr),
    .mem_d_cacheable_i(d_cache), .mem_d_req_tag_i(d_tag), .mem_d_invalidate_i(d_inv),
    .mem_d_writeback_i(d_wb), .mem_d_flush_i(d_flush),
    .mem_d_data_rd_o(d_rdata), .mem_d_accept_o(d_accept), .mem_d_ack_o(d_ack),
    .mem_d_error_o(d_error), .mem_d_resp_tag_o(d_rtag)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, wanted %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        i_rd;
    logic [31:0] pc;
    logic        d_rd;
    logic [3:0]  d_wr;
    logic        d_flush;
    logic [31:0] d_addr;
    logic [31:0] d_data;
    logic [10:0] tag;
    logic        e_ivld;
    logic [63:0] e_inst;
    logic        e_ack;
    logic [10:0] e_tag;
    logic [31:0] e_drd;
  } vec_t;

  logic [63:0] pre [0:8];
  vec_t        vecs [0:20];

  initial begin
    pre[0] = 64'h0000_0000_0000_0013;
    pre[1] = 64'h0020_0113_0010_0093;
    pre[2] = 64'h0040_0213_0030_0193;
    pre[3] = 64'h0060_0313_0050_0293;
    pre[4] = 64'h0080_0413_0070_0393;
    pre[5] = 64'h00A0_0513_0090_0493;
    pre[6] = 64'h00C0_0613_00B0_0593;
    pre[7] = 64'h00E0_0713_00D0_0693;
    pre[8] = 64'h0100_0813_00F0_0793;

    //         i_rd pc            d_rd wr     fl  d_addr        d_data        tag      ivld inst                    ack tag      drd
    vecs[0]  = '{1'b1, 32'h8000_0000, 1'b0, 4'h0, 1'b0, 32'h0,        32'h0,        11'h000, 1'b1, 64'h0000_0000_0000_0013, 1'b0, 11'h000, 32'h0000_0000};
    vecs[1]  = '{1'b0, 32'h0,         1'b0, 4'hF, 1'b0, 32'h8000_9000, 32'h0123_4567, 11'h005, 1'b0, 64'h0, 1'b1, 11'h005, 32'h0000_0000};
    vecs[2]  = '{1'b0, 32'h0,         1'b0, 4'hF, 1'b0, 32'h8000_9004, 32'hC0FF_EE00, 11'h006, 1'b0, 64'h0, 1'b1, 11'h006, 32'h0000_0000};
    vecs[3]  = '{1'b0, 32'h0,         1'b1, 4'h0, 1'b0, 32'h8000_9004, 32'h0,        11'h007, 1'b0, 64'h0, 1'b1, 11'h007, 32'hC0FF_EE00};
    vecs[4]  = '{1'b0, 32'h0,         1'b1, 4'h0, 1'b0, 32'h8000_9000, 32'h0,        11'h7FF, 1'b0, 64'h0, 1'b1, 11'h7FF, 32'h0123_4567};
    vecs[5]  = '{1'b0, 32'h0,         1'b0, 4'hF, 1'b0, 32'h8000_9010, 32'h1122_3344, 11'h001, 1'b0, 64'h0, 1'b1, 11'h001, 32'h0123_4567};
    vecs[6]  = '{1'b0, 32'h0,         1'b0, 4'h2, 1'b0, 32'h8000_9010, 32'h0000_AB00, 11'h002, 1'b0, 64'h0, 1'b1, 11'h002, 32'h0123_4567};
    vecs[7]  = '{1'b0, 32'h0,         1'b1, 4'h0, 1'b0, 32'h8000_9010, 32'h0,        11'h003, 1'b0, 64'h0, 1'b1, 11'h003, 32'h1122_AB44};
    vecs[8]  = '{1'b0, 32'h0,         1'b0, 4'h0, 1'b0, 32'h0,         32'h0,        11'h000, 1'b0, 64'h0, 1'b0, 11'h000, 32'h1122_AB44};
    vecs[9]  = '{1'b0, 32'h0,         1'b0, 4'h0, 1'b1, 32'h8000_9000, 32'h0,        11'h155, 1'b0, 64'h0, 1'b1, 11'h155, 32'h1122_AB44};
    vecs[10] = '{1'b1, 32'h8002_0000, 1'b1, 4'h0, 1'b0, 32'h0002_9004, 32'h0,        11'h004, 1'b1, 64'h0000_0000_0000_0013, 1'b1, 11'h004, 32'hC0FF_EE00};
    vecs[11] = '{1'b1, 32'h8000_9000, 1'b0, 4'hF, 1'b0, 32'h8000_9000, 32'hDEAD_BEEF, 11'h009, 1'b1, 64'hC0FF_EE00_0123_4567, 1'b1, 11'h009, 32'hC0FF_EE00};
    vecs[12] = '{1'b0, 32'h0,         1'b1, 4'h0, 1'b0, 32'h8000_9000, 32'h0,        11'h00A, 1'b0, 64'h0, 1'b1, 11'h00A, 32'hDEAD_BEEF};
    vecs[13] = '{1'b1, 32'h8000_0008, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0, 11'h0, 1'b1, 64'h0020_0113_0010_0093, 1'b0, 11'h0, 32'hDEAD_BEEF};
    vecs[14] = '{1'b1, 32'h8000_0010, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0, 11'h0, 1'b1, 64'h0040_0213_0030_0193, 1'b0, 11'h0, 32'hDEAD_BEEF};
    vecs[15] = '{1'b1, 32'h8000_0018, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0, 11'h0, 1'b1, 64'h0060_0313_0050_0293, 1'b0, 11'h0, 32'hDEAD_BEEF};
    vecs[16] = '{1'b1, 32'h8000_0020, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0, 11'h0, 1'b1, 64'h0080_0413_0070_0393, 1'b0, 11'h0, 32'hDEAD_BEEF};
    vecs[17] = '{1'b1, 32'h8000_0028, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0, 11'h0, 1'b1, 64'h00A0_0513_0090_0493, 1'b0, 11'h0, 32'hDEAD_BEEF};
    vecs[18] = '{1'b1, 32'h8000_0030, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0, 11'h0, 1'b1, 64'h00C0_0613_00B0_0593, 1'b0, 11'h0, 32'hDEAD_BEEF};
    vecs[19] = '{1'b1, 32'h8000_0038, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0, 11'h0, 1'b1, 64'h00E0_0713_00D0_0693, 1'b0, 11'h0, 32'hDEAD_BEEF};
    vecs[20] = '{1'b1, 32'h8000_0040, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0, 11'h0, 1'b1, 64'h0100_0813_00F0_0793, 1'b0, 11'h0, 32'hDEAD_BEEF};

    // Backdoor preload, byte by byte, little-endian.
    for (int w = 0; w < 9; w++) begin
      for (int b = 0; b < 8; b++) begin
        dut.write(32'h8000_0000 + 32'(w * 8 + b), pre[w][b*8 +: 8]);
      end
    end

    // Reset state while reset is held over a couple of edges.
    repeat (2) @(posedge clk);
    #1;
    check("rst_ivalid", {63'd0, i_valid}, 64'd0);
    check("rst_inst", i_inst, 64'd0);
    check("rst_ack", {63'd0, d_ack}, 64'd0);
    check("rst_rtag", {53'd0, d_rtag}, 64'd0);
    check("rst_drd", {32'd0, d_rdata}, 64'd0);
    check("tied_outs", {60'd0, i_accept, i_error, d_accept, d_error}, 64'hA);
    check("backdoor_w0", dut.u_ram.ram[0], 64'h0000_0000_0000_0013);
    rst = 1'b0;

    // Table: apply one row per cycle, compare the registered response.
    for (int k = 0; k < 21; k++) begin
      i_rd = vecs[k].i_rd;     i_pc = vecs[k].pc;
      d_rd = vecs[k].d_rd;     d_wr = vecs[k].d_wr;   d_flush = vecs[k].d_flush;
      d_addr = vecs[k].d_addr; d_wdata = vecs[k].d_data; d_tag = vecs[k].tag;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_ivalid", k), {63'd0, i_valid}, {63'd0, vecs[k].e_ivld});
      if (vecs[k].e_ivld) check($sformatf("v%0d_inst", k), i_inst, vecs[k].e_inst);
      check($sformatf("v%0d_ack", k), {63'd0, d_ack}, {63'd0, vecs[k].e_ack});
      if (vecs[k].e_ack) check($sformatf("v%0d_rtag", k), {53'd0, d_rtag}, {53'd0, vecs[k].e_tag});
      check($sformatf("v%0d_drd", k), {32'd0, d_rdata}, {32'd0, vecs[k].e_drd});
      if (k == 2) check("ram_1200_after_stores", dut.u_ram.ram[14'h1200], 64'hC0FF_EE00_0123_4567);
    end

    // RAM contents after the table.
    check("ram_1200_final", dut.u_ram.ram[14'h1200], 64'hC0FF_EE00_DEAD_BEEF);
    check("ram_1202_lo", {32'd0, dut.u_ram.ram[14'h1202][31:0]}, 64'h1122_AB44);

    // Reset in the middle of a cycle with responses in flight.
    i_rd = 1'b1; i_pc = 32'h8000_0008;
    d_rd = 1'b0; d_wr = 4'hF; d_flush = 1'b0; d_addr = 32'h8000_9008; d_wdata = 32'h55AA_55AA; d_tag = 11'h033;
    @(posedge clk);
    #1;
    check("pre_rst_ivalid", {63'd0, i_valid}, 64'd1);
    check("pre_rst_ack", {63'd0, d_ack}, 64'd1);
    i_rd = 1'b0; d_wr = 4'h0; d_tag = 11'h0;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ivalid", {63'd0, i_valid}, 64'd0);
    check("mid_rst_inst", i_inst, 64'd0);
    check("mid_rst_ack", {63'd0, d_ack}, 64'd0);
    check("mid_rst_rtag", {53'd0, d_rtag}, 64'd0);
    check("mid_rst_drd", {32'd0, d_rdata}, 64'd0);
    check("store_survives_rst", {32'd0, dut.u_ram.ram[14'h1201][31:0]}, 64'h55AA_55AA);
    @(negedge clk);
    rst = 1'b0;

    // After reset: load the stored word back through the aliased window.
    @(posedge clk);
    #1;
    d_rd = 1'b1; d_addr = 32'h0000_9008; d_tag = 11'h044;
    @(posedge clk);
    #1;
    check("post_rst_ack", {63'd0, d_ack}, 64'd1);
    check("post_rst_rtag", {53'd0, d_rtag}, 64'h044);
    check("post_rst_load", {32'd0, d_rdata}, 64'h55AA_55AA);
    d_rd = 1'b0;
    @(posedge clk);
    #1;
    check("idle_ack", {63'd0, d_ack}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
